pl_mem_ctrl: RTL and testbench
==============================

PL_MEM_CTRL -- requirements
Module: pl_mem_ctrl

Interface
REQ-001 clock  in  1  pipeline clock; all state updates on rising edge.
REQ-002 resetn  in  1  reset; asynchronous, active-low.
REQ-003 ex_op  in  4  memory op from EX/MEM register: 0 NOP, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; other codes are treated as NOP.
REQ-004 ex_addr  in  32  byte address of access.
REQ-005 ex_data  in  32  store data, right-justified.
REQ-006 mem_we  out  1  write strobe to data-memory/IO stage.
REQ-007 mem_addr  out  32  word address to data-memory/IO stage; bits [1:0] always 0.
REQ-008 mem_datain  out  32  word write data.
REQ-009 mem_dataout  in  32  word read data, valid combinationally in the same cycle as mem_addr.
REQ-010 stall  out  1  high: upstream holds ex_* for the next cycle.
REQ-011 wb_load  out  1  registered; the previous cycle completed a load.
REQ-012 wb_data  out  32  registered, aligned and extended load result.
REQ-013 misalign_err  out  1  registered one-cycle pulse (PL_MEM_CTRL_ALIGN_CHK_EN only).

Function
REQ-014 FSM states: IDLE and RMW_WR.
REQ-015 IDLE, load op: mem_addr={ex_addr[31:2],2'b00}, mem_we=0; at the edge, wb_load=1 and wb_data=selected byte/half, sign-extended (LB, LH) or zero-extended (LBU, LHU); latency 1 cycle; stall=0.
REQ-016 Byte select uses ex_addr[1:0], half select uses ex_addr[1]; little-endian (byte 0 = bits [7:0]).
REQ-017 IDLE, SW: mem_we=1, mem_datain=ex_data, stall=0; single cycle.
REQ-018 IDLE, SH/SB to memory space (ex_addr[7]=0): read-modify-write; cycle 1 drives read address, stall=1, captures mem_dataout merged with the new byte/half into a merge register, moves to RMW_WR.
REQ-019 RMW_WR: mem_we=1, mem_addr held from cycle 1, mem_datain=merge register, stall=0, returns to IDLE; total 2 cycles.
REQ-020 SH/SB to IO space (ex_addr[7]=1): no read phase; single-cycle word write of zero-extended byte/half; stall=0.
REQ-021 Any non-load cycle (including store cycles and RMW_WR) clears wb_load at the edge; wb_data holds its value.
REQ-022 NOP: mem_we=0, stall=0, no state change.
REQ-023 mem_we is never high in a cycle where stall=1.
REQ-024 Misalignment: LW/SW with ex_addr[1:0]!=0, or LH/LHU/SH with ex_addr[0]=1.

Reset
REQ-025 resetn low forces IDLE, wb_load=0, wb_data=0, misalign_err=0, merge register=0, immediately and asynchronously.
REQ-026 Reset during RMW_WR aborts the write; mem_we=0 while resetn is low; no write is issued after release.
REQ-027 Combinational outputs while resetn is low: stall=0, mem_we=0.

Configuration
REQ-028 Macro PL_MEM_CTRL_ALIGN_CHK_EN defined: a misaligned access is suppressed (no write, no RMW, wb_load=0) and misalign_err pulses high for the following cycle.
REQ-029 Macro undefined: misaligned accesses execute with offending low address bits forced to 0, and misalign_err is tied 0.

Structure
REQ-030 Shared package pl_mem_pkg holds the ex_op encodings, the FSM state typedef, and the IO region bit index (7).
REQ-031 One sub-module, pl_mem_align, is a purely combinational block that performs load extraction/extension and store byte/half merge; the FSM and registers live in pl_mem_ctrl.

Verification
REQ-032 Memory word 0x10=0x8899AABB; LB @0x11 -> next cycle wb_load=1, wb_data=0xFFFFFFAA; LBU @0x11 -> 0x000000AA.
REQ-033 Word 0x20=0x11223344; SB @0x22 data 0x55 -> stall=1 for 1 cycle, then mem_we=1 with mem_datain=0x11553344 at mem_addr 0x20; LW @0x20 -> 0x11553344.
REQ-034 SH @0x84 data 0xBEEF -> single cycle, stall=0, mem_we=1, mem_datain=0x0000BEEF, mem_addr=0x84.
REQ-035 With PL_MEM_CTRL_ALIGN_CHK_EN: LW @0x13 -> mem_we=0, wb_load=0, misalign_err=1 for one cycle; without the macro -> reads word 0x10.
REQ-036 SB @0x30 started, then resetn pulsed low during RMW_WR -> no write; word 0x30 is unchanged; state=IDLE.
REQ-037 Back-to-back SB @0x40, LW @0x40 -> the load returns the merged word (write precedes read).

Source files
------------

// File: rtl/pl_mem_pkg.sv
// Shared definitions for the pipeline memory-stage controller: op encodings,
// FSM states, IO region bit and small address helpers.
package pl_mem_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LW  = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LB  = 4'd4,
    OP_LBU = 4'd5,
    OP_SW  = 4'd6,
    OP_SH  = 4'd7,
    OP_SB  = 4'd8
  } mem_op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } state_e;

  localparam int IO_BIT = 7;

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
    case (op)
      OP_LW, OP_SW:         return off != 2'b00;
      OP_LH, OP_LHU, OP_SH: return off[0];
      default:              return 1'b0;
    endcase
  endfunction

  // Clears only the low address bits that a word/half access is not allowed to carry.
  function automatic logic [1:0] force_align(input logic [3:0] op, input logic [1:0] off);
    case (op)
      OP_LW, OP_SW:         return 2'b00;
      OP_LH, OP_LHU, OP_SH: return {off[1], 1'b0};
      default:              return off;
    endcase
  endfunction

endpackage

// File: rtl/pl_mem_ctrl_if.sv
// Pipeline-side and memory-side signals of the memory-stage controller.
interface pl_mem_ctrl_if;
  logic [3:0]  ex_op;
  logic [31:0] ex_addr;
  logic [31:0] ex_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_datain;
  logic [31:0] mem_dataout;
  logic        stall;
  logic        wb_load;
  logic [31:0] wb_data;
  logic        misalign_err;

  modport master (
    output ex_op, ex_addr, ex_data, mem_dataout,
    input  mem_we, mem_addr, mem_datain, stall, wb_load, wb_data, misalign_err
  );

  modport slave (
    input  ex_op, ex_addr, ex_data, mem_dataout,
    output mem_we, mem_addr, mem_datain, stall, wb_load, wb_data, misalign_err
  );
endinterface

// File: rtl/pl_mem_align.sv
// Combinational lane logic: load extraction with sign/zero extension, byte/half
// merge into a read word, and zero-extended IO store data.
module pl_mem_align
  import pl_mem_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_sdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge,
  output logic [31:0] o_io
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
  assign w_half = i_rdata[{i_off[1], 4'b0000} +: 16];

  always_comb begin
    o_load = '0;
    case (i_op)
      OP_LW:   o_load = i_rdata;
      OP_LH:   o_load = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_load = {16'h0000, w_half};
      OP_LB:   o_load = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_load = {24'h000000, w_byte};
      default: o_load = '0;
    endcase
  end

  always_comb begin
    o_merge = i_rdata;
    o_io    = i_sdata;
    case (i_op)
      OP_SH: begin
        o_merge[{i_off[1], 4'b0000} +: 16] = i_sdata[15:0];
        o_io = {16'h0000, i_sdata[15:0]};
      end
      OP_SB: begin
        o_merge[{i_off, 3'b000} +: 8] = i_sdata[7:0];
        o_io = {24'h000000, i_sdata[7:0]};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/pl_mem_ctrl.sv
// Memory-stage controller: word-addressed loads/stores with read-modify-write
// for sub-word stores to memory space. Option: PL_MEM_CTRL_ALIGN_CHK_EN.
module pl_mem_ctrl
  import pl_mem_pkg::*;
(
  input  logic         clock,
  input  logic         resetn,
  pl_mem_ctrl_if.slave bus
);
  state_e      r_state, w_state_nxt;
  logic        r_wb_load;
  logic [31:0] r_wb_data;
  logic [31:0] r_merge;
  logic [29:0] r_rmw_word;

  logic [3:0]  w_op;
  logic [1:0]  w_off;
  logic        w_suppress;
  logic        w_io;
  logic        w_we, w_stall, w_ld, w_rmw_start;
  logic [31:0] w_addr, w_wdata, w_load, w_merge, w_io_data;

  assign w_op = bus.ex_op;
  assign w_io = bus.ex_addr[IO_BIT];

`ifdef PL_MEM_CTRL_ALIGN_CHK_EN
  logic r_misalign;
  assign w_suppress = is_misaligned(w_op, bus.ex_addr[1:0]);
  assign w_off      = bus.ex_addr[1:0];
`else
  assign w_suppress = 1'b0;
  assign w_off      = force_align(w_op, bus.ex_addr[1:0]);
`endif

  pl_mem_align u_align (
    .i_op    (w_op),
    .i_off   (w_off),
    .i_rdata (bus.mem_dataout),
    .i_sdata (bus.ex_data),
    .o_load  (w_load),
    .o_merge (w_merge),
    .o_io    (w_io_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_stall     = 1'b0;
    w_ld        = 1'b0;
    w_rmw_start = 1'b0;
    w_addr      = {bus.ex_addr[31:2], 2'b00};
    w_wdata     = bus.ex_data;
    case (r_state)
      ST_IDLE: begin
        if (!w_suppress) begin
          case (w_op)
            OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: w_ld = 1'b1;
            OP_SW: w_we = 1'b1;
            OP_SH, OP_SB: begin
              if (w_io) begin
                w_we    = 1'b1;
                w_wdata = w_io_data;
              end else begin
                w_stall     = 1'b1;
                w_rmw_start = 1'b1;
                w_state_nxt = ST_RMW_WR;
              end
            end
            default: ;
          endcase
        end
      end
      ST_RMW_WR: begin
        w_we        = 1'b1;
        w_addr      = {r_rmw_word, 2'b00};
        w_wdata     = r_merge;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Held in reset: never write, never ask upstream to hold.
    if (!resetn) begin
      w_we    = 1'b0;
      w_stall = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_wb_load <= 1'b0;
      r_wb_data <= '0;
      r_merge   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wb_load <= w_ld;
      if (w_ld)        r_wb_data <= w_load;
      if (w_rmw_start) r_merge   <= w_merge;
    end
  end

  always_ff @(posedge clock) begin
    if (w_rmw_start) r_rmw_word <= bus.ex_addr[31:2];
  end

`ifdef PL_MEM_CTRL_ALIGN_CHK_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_misalign <= 1'b0;
    else         r_misalign <= w_suppress && (r_state == ST_IDLE);
  end
  assign bus.misalign_err = r_misalign;
`else
  assign bus.misalign_err = 1'b0;
`endif

  assign bus.mem_we     = w_we;
  assign bus.mem_addr   = w_addr;
  assign bus.mem_datain = w_wdata;
  assign bus.stall      = w_stall;
  assign bus.wb_load    = r_wb_load;
  assign bus.wb_data    = r_wb_data;
endmodule

// File: tb/tb_pl_mem_ctrl.sv
// Self-checking bench for pl_mem_ctrl: vector table with a load scoreboard plus
// hand-written reset, back-to-back and misalignment sequences.
module tb_pl_mem_ctrl;
  import pl_mem_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    bit          rmw;
    bit          we;
    logic [31:0] maddr;
    logic [31:0] wdata;
    bit          ld;
    logic [31:0] wb;
  } vec_t;

  logic clock;
  logic resetn;
  logic preload;
  int   n_checks;
  int   n_fail;
  logic [31:0] last_wb;
  logic [31:0] sb_q[$];
  logic [31:0] mem [0:255];
  vec_t vecs [18];

  pl_mem_ctrl_if bus ();

  pl_mem_ctrl dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign bus.mem_dataout = mem[bus.mem_addr[9:2]];

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h04] <= 32'h8899AABB;
      mem[8'h08] <= 32'h11223344;
      mem[8'h0C] <= 32'hCAFEF00D;
      mem[8'h10] <= 32'h01020304;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[9:2]] <= bus.mem_datain;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                              input bit rmw, input bit we, input logic [31:0] maddr,
                              input logic [31:0] wdata, input bit ld, input logic [31:0] wb);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.rmw = rmw; v.we = we;
    v.maddr = maddr; v.wdata = wdata; v.ld = ld; v.wb = wb;
    return v;
  endfunction

  task automatic check_wb(input bit ld);
    logic [31:0] exp;
    chk("wb_load", {31'b0, bus.wb_load}, {31'b0, ld});
    if (ld) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty: got load with no expectation");
      end else begin
        exp = sb_q.pop_front();
        chk("wb_data", bus.wb_data, exp);
        last_wb = exp;
      end
    end else begin
      chk("wb_hold", bus.wb_data, last_wb);
    end
  endtask

  // Drives one op just after a rising edge; RMW stores take a second cycle.
  task automatic run_vec(input vec_t v);
    bus.ex_op   = v.op;
    bus.ex_addr = v.addr;
    bus.ex_data = v.data;
    if (v.ld) sb_q.push_back(v.wb);
    @(negedge clock);
    chk("stall", {31'b0, bus.stall}, {31'b0, v.rmw});
    chk("mem_we", {31'b0, bus.mem_we}, {31'b0, v.we && !v.rmw});
    if (v.ld || v.we) chk("mem_addr", bus.mem_addr, v.maddr);
    if (v.we && !v.rmw) chk("mem_datain", bus.mem_datain, v.wdata);
    @(posedge clock); #1;
    if (v.rmw) begin
      check_wb(1'b0);
      @(negedge clock);
      chk("rmw_stall", {31'b0, bus.stall}, 32'd0);
      chk("rmw_we", {31'b0, bus.mem_we}, 32'd1);
      chk("rmw_addr", bus.mem_addr, v.maddr);
      chk("rmw_data", bus.mem_datain, v.wdata);
      @(posedge clock); #1;
    end
    check_wb(v.ld);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    last_wb  = 32'h0;
    preload  = 1'b1;
    resetn   = 1'b0;
    bus.ex_op   = OP_SB;
    bus.ex_addr = 32'h20;
    bus.ex_data = 32'h0;

    vecs[0]  = mk(OP_LB,  32'h11, 32'h0,        0, 0, 32'h10, 32'h0,        1, 32'hFFFFFFAA);
    vecs[1]  = mk(OP_LBU, 32'h11, 32'h0,        0, 0, 32'h10, 32'h0,        1, 32'h000000AA);
    vecs[2]  = mk(OP_LH,  32'h12, 32'h0,        0, 0, 32'h10, 32'h0,        1, 32'hFFFF8899);
    vecs[3]  = mk(OP_LHU, 32'h10, 32'h0,        0, 0, 32'h10, 32'h0,        1, 32'h0000AABB);
    vecs[4]  = mk(OP_LB,  32'h13, 32'h0,        0, 0, 32'h10, 32'h0,        1, 32'hFFFFFF88);
    vecs[5]  = mk(OP_SB,  32'h22, 32'h55,       1, 1, 32'h20, 32'h11553344, 0, 32'h0);
    vecs[6]  = mk(OP_LW,  32'h20, 32'h0,        0, 0, 32'h20, 32'h0,        1, 32'h11553344);
    vecs[7]  = mk(OP_SH,  32'h84, 32'hDEADBEEF, 0, 1, 32'h84, 32'h0000BEEF, 0, 32'h0);
    vecs[8]  = mk(OP_SW,  32'h24, 32'h12345678, 0, 1, 32'h24, 32'h12345678, 0, 32'h0);
    vecs[9]  = mk(OP_LW,  32'h24, 32'h0,        0, 0, 32'h24, 32'h0,        1, 32'h12345678);
    vecs[10] = mk(OP_SH,  32'h22, 32'h0000A5A5, 1, 1, 32'h20, 32'hA5A53344, 0, 32'h0);
    vecs[11] = mk(OP_LBU, 32'h23, 32'h0,        0, 0, 32'h20, 32'h0,        1, 32'h000000A5);
    vecs[12] = mk(OP_NOP, 32'h20, 32'hFFFFFFFF, 0, 0, 32'h0,  32'h0,        0, 32'h0);
    vecs[13] = mk(OP_SB,  32'h40, 32'hEE,       1, 1, 32'h40, 32'h010203EE, 0, 32'h0);
    vecs[14] = mk(OP_LW,  32'h40, 32'h0,        0, 0, 32'h40, 32'h0,        1, 32'h010203EE);
    vecs[15] = mk(OP_SB,  32'h85, 32'h1FF,      0, 1, 32'h84, 32'h000000FF, 0, 32'h0);
    vecs[16] = mk(4'd9,   32'h20, 32'h0,        0, 0, 32'h0,  32'h0,        0, 32'h0);
    vecs[17] = mk(OP_LH,  32'h20, 32'h0,        0, 0, 32'h20, 32'h0,        1, 32'h00003344);

    // Reset state, with an RMW store presented to show outputs stay gated.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_stall", {31'b0, bus.stall}, 32'd0);
    chk("rst_we", {31'b0, bus.mem_we}, 32'd0);
    chk("rst_wb_load", {31'b0, bus.wb_load}, 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'h0);
    chk("rst_misalign", {31'b0, bus.misalign_err}, 32'd0);
    bus.ex_op = OP_NOP;
    preload = 1'b0;
    resetn  = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 18; i++) run_vec(vecs[i]);

    // Reset asserted while the RMW write cycle is on the bus.
    bus.ex_op   = OP_SB;
    bus.ex_addr = 32'h30;
    bus.ex_data = 32'h77;
    @(negedge clock);
    chk("abort_stall", {31'b0, bus.stall}, 32'd1);
    @(posedge clock); #1;
    chk("abort_pre_we", {31'b0, bus.mem_we}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("abort_we", {31'b0, bus.mem_we}, 32'd0);
    chk("abort_stall_rst", {31'b0, bus.stall}, 32'd0);
    chk("abort_wb_data", bus.wb_data, 32'h0);
    last_wb = 32'h0;
    @(posedge clock); #1;
    bus.ex_op = OP_NOP;
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("abort_post_we", {31'b0, bus.mem_we}, 32'd0);
    chk("abort_post_stall", {31'b0, bus.stall}, 32'd0);
    chk("abort_word", mem[8'h0C], 32'hCAFEF00D);
    @(posedge clock); #1;
    run_vec(mk(OP_LW, 32'h30, 32'h0, 0, 0, 32'h30, 32'h0, 1, 32'hCAFEF00D));

    // Misaligned word load.
`ifdef PL_MEM_CTRL_ALIGN_CHK_EN
    bus.ex_op   = OP_LW;
    bus.ex_addr = 32'h13;
    @(negedge clock);
    chk("mis_we", {31'b0, bus.mem_we}, 32'd0);
    chk("mis_stall", {31'b0, bus.stall}, 32'd0);
    @(posedge clock); #1;
    check_wb(1'b0);
    chk("mis_err", {31'b0, bus.misalign_err}, 32'd1);
    bus.ex_op = OP_NOP;
    @(posedge clock); #1;
    chk("mis_err_clear", {31'b0, bus.misalign_err}, 32'd0);
`else
    run_vec(mk(OP_LW, 32'h13, 32'h0, 0, 0, 32'h10, 32'h0, 1, 32'h8899AABB));
    chk("mis_err_tied", {31'b0, bus.misalign_err}, 32'd0);
`endif

    bus.ex_op = OP_NOP;
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
